// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, access size codes, LSU error codes, AXI response
// codes, captured request control struct and the misalignment helper.
package mem_lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW_W,
      S_B,
      S_RESP
   } lsu_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_BUS      = 2'd2;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Control fields captured with the address at request accept.
   typedef struct packed {
      logic       wr;
      logic [1:0] size;
      logic       sign_ext;
   } req_ctl_t;

   // Natural alignment check on the low address bits. A doubleword access is
   // only legal on a 64-bit data path.
   function automatic logic is_misaligned(input logic [2:0] lo,
                                          input logic [1:0] size,
                                          input logic       dw64);
      logic mis;
      mis = 1'b0;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = lo[0];
         SIZE_W:  mis = (lo[1:0] != 2'b00);
         SIZE_D:  mis = !dw64 || (lo != 3'b000);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Anything other than OKAY is treated as a bus error on this port.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != AXI_RESP_OKAY);
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment: store data/strobe shift and load extract/extend.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   off       byte offset of the access inside the bus word
//   size      access size (B/H/W/D)
//   sign_ext  load: sign-extend from the top bit of the extracted field
//   st_data   LSB-justified store data   -> wdata/wstrb lane-shifted
//   ld_raw    raw bus read word          -> ld_data extracted and extended
module mem_lsu_align
   import mem_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int STRB_W     = DATA_WIDTH / 8,
   parameter int OFF_W      = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]      off,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [STRB_W-1:0]     wstrb,
   input  logic [DATA_WIDTH-1:0] ld_raw,
   output logic [DATA_WIDTH-1:0] ld_data
);

   logic [STRB_W-1:0]     base_strb;
   logic [DATA_WIDTH-1:0] shifted;
   logic                  sbit;
   int                    nbytes;
   int                    nbits;

   always_comb begin
      nbytes = 1 << size;
      nbits  = 8 << size;

      // Strobe for an access of nbytes starting at lane 0, then moved to off.
      base_strb = '0;
      for (int i = 0; i < STRB_W; i++) begin
         base_strb[i] = (i < nbytes);
      end
      wstrb = base_strb << off;
      wdata = st_data << {off, 3'b000};

      // Bring the addressed field down to bit 0, then fill above it.
      shifted = ld_raw >> {off, 3'b000};
      case (size)
         SIZE_B:  sbit = shifted[7];
         SIZE_H:  sbit = shifted[15];
         SIZE_W:  sbit = shifted[31];
         default: sbit = shifted[DATA_WIDTH-1];
      endcase
      ld_data = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         ld_data[i] = (i < nbits) ? shifted[i] : (sign_ext & sbit);
      end
   end

endmodule

// File: rtl/mem_lsu_axi.sv
// Blocking MEM-stage load/store unit onto an AXI4-Lite data port.
// Latency (zero-wait slave): load 3, store 3, misaligned 1 cycle accept->rsp_valid.
// Backpressure: req_ready low while busy; rsp_valid held until rsp_ready; AXI valids held until handshake.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_*                           one load/store request from the MEM stage
//   rsp_*                           response: extended load data and error code
//   ar*/r*                          AXI-Lite read address / read data channels
//   aw*/w*/b*                       AXI-Lite write address / write data / write response
module mem_lsu_axi
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // request
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wr,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   // response
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_err,
   // AXI-Lite read
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   // AXI-Lite write
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int   STRB_W = DATA_WIDTH / 8;
   localparam int   OFF_W  = $clog2(STRB_W);
   localparam logic DW64   = (DATA_WIDTH == 64);

   lsu_state_e             state, state_nxt;
   req_ctl_t               ctl_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic                   aw_done, w_done;
   logic                   rdy_q;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q;
   logic [1:0]             rsp_err_q;

   logic                   accept;
   logic                   req_mis;
   logic [DATA_WIDTH-1:0]  ld_data;

   assign accept  = req_valid && rdy_q;
   assign req_mis = is_misaligned(req_addr[2:0], req_size, DW64);

   mem_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .off      (addr_q[OFF_W-1:0]),
      .size     (ctl_q.size),
      .sign_ext (ctl_q.sign_ext),
      .st_data  (wdata_q),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .ld_raw   (rdata),
      .ld_data  (ld_data)
   );

   // Both channels address the whole bus word; lanes are picked by wstrb / extraction.
   assign araddr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign awaddr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

   // req_ready is registered from next_state so that it is low while reset is
   // held and otherwise equals (state == S_IDLE).
   assign req_ready = rdy_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_mis)     state_nxt = S_RESP;
               else if (req_wr) state_nxt = S_AW_W;
               else             state_nxt = S_AR;
            end
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) state_nxt = S_RESP;
         end
         S_AW_W: begin
            // Each channel drops its valid once its own handshake is done.
            awvalid = !aw_done;
            wvalid  = !w_done;
            if ((aw_done || awready) && (w_done || wready)) state_nxt = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q       <= 1'b0;
         ctl_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_OK;
      end else begin
         rdy_q <= (state_nxt == S_IDLE);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  ctl_q.wr       <= req_wr;
                  ctl_q.size     <= req_size;
                  ctl_q.sign_ext <= req_signed;
                  addr_q         <= req_addr;
                  wdata_q        <= req_wdata;
                  aw_done        <= 1'b0;
                  w_done         <= 1'b0;
                  rsp_rdata_q    <= '0;
                  rsp_err_q      <= req_mis ? ERR_MISALIGN : ERR_OK;
               end
            end
            S_AW_W: begin
               if (awvalid && awready) aw_done <= 1'b1;
               if (wvalid && wready)   w_done  <= 1'b1;
            end
            S_R: begin
               if (rvalid) begin
                  if (resp_is_err(rresp)) begin
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= ERR_BUS;
                  end else begin
                     rsp_rdata_q <= ld_data;
                     rsp_err_q   <= ERR_OK;
                  end
               end
            end
            S_B: begin
               if (bvalid) begin
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= resp_is_err(bresp) ? ERR_BUS : ERR_OK;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
